// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Fixed-latency data-memory responder with busy/stall output.
// Revision : 1.0
// ============================================================================
module dmem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        req_write,
    input  logic [63:0] req_wdata,
    input  logic [3:0]  req_size,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int c_MEM_BYTES = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic        r_write;
    logic [3:0]  r_size;
    logic [63:0] r_rdata;
    logic        r_err;
    logic [7:0]  r_mem [c_MEM_BYTES];

    logic                 w_accept;
    logic                 w_mem_edge;
    logic                 w_size_ok;
    logic                 w_misaligned;
    logic                 w_high_bits;
    logic [ADDR_BITS:0]   w_end;
    logic                 w_over;
    logic                 w_err;
    logic [63:0]          w_load;

    assign req_ready  = (r_state != S_WAIT);
    assign busy       = (r_state != S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    assign w_accept   = req_valid && req_ready;
    assign w_mem_edge = (r_state == S_WAIT) && (r_cnt == 4'd0);

    // Request checks are made on the latched copy, never on live req_* pins.
    assign w_size_ok    = (r_size == 4'd1) || (r_size == 4'd2) ||
                          (r_size == 4'd4) || (r_size == 4'd8);
    assign w_misaligned = (r_addr[3:0] & (r_size - 4'd1)) != 4'd0;
    assign w_high_bits  = |r_addr[63:ADDR_BITS];
    assign w_end        = {1'b0, r_addr[ADDR_BITS-1:0]} + {{(ADDR_BITS-3){1'b0}}, r_size};
    assign w_over       = w_end[ADDR_BITS] && (|w_end[ADDR_BITS-1:0]);
    assign w_err        = !w_size_ok || w_misaligned || w_high_bits || w_over;

    always_comb begin
        w_load = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < r_size)
                w_load[8*i +: 8] = r_mem[r_addr[ADDR_BITS-1:0] + ADDR_BITS'(i)];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
            // A request already waiting is taken on the edge that leaves RESP.
            S_RESP:  w_next = req_valid ? S_WAIT : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_size  <= 4'd0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt   <= 4'(LATENCY - 1);
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_write <= req_write;
                r_size  <= req_size;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_mem_edge) begin
                r_rdata <= (r_write || w_err) ? 64'd0 : w_load;
                r_err   <= w_err;
            end else begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    // Storage has no reset; reset on the access edge still blocks the store.
    always_ff @(posedge clk) begin
        if (!reset && w_mem_edge && r_write && !w_err) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < r_size)
                    r_mem[r_addr[ADDR_BITS-1:0] + ADDR_BITS'(i)] <= r_wdata[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire
